// File: rtl/array_4_arb_pkg.sv
// Shared types and default widths for the two-requester SRAM arbiter.
package array_4_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 8;
  localparam int unsigned ARB_DATA_W = 8;
  localparam int unsigned ARB_MASK_W = 4;

  // Arbiter operating state: INIT clears the array, RUN serves requesters.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  // Requester index (two requesters).
  typedef logic req_idx_t;

endpackage

// File: rtl/array_4_arbiter_if.sv
// Requester and SRAM-port bundle for array_4_arbiter.
// slave: arbiter view; master: requesters plus SRAM macro view.
interface array_4_arbiter_if
  import array_4_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned MASK_W = ARB_MASK_W
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*MASK_W-1:0] req_wmask;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                init_done;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_en;
  logic                mem_wmode;
  logic [MASK_W-1:0]   mem_wmask;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, init_done,
           mem_addr, mem_en, mem_wmode, mem_wmask, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, init_done,
           mem_addr, mem_en, mem_wmode, mem_wmask, mem_wdata
  );

endinterface

// File: rtl/array_4_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational; on contention the
// requester that was not granted last wins. Pointer tracks the last grant.
module rr_arb2
  import array_4_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  req_idx_t ptr_q, ptr_d;

  // Grant selection from valids and last-granted pointer.
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer follows the granted index, held when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i && (|grant_o)) begin
      ptr_d = grant_o[1];
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/array_4_arbiter.sv
// Two-requester round-robin front end for a single-port masked-write SRAM.
// Read data returns one cycle after issue, tagged by resp_valid bit.
// Optional power-on clear of the whole array: define ARRAY_4_ARB_INIT_EN.
module array_4_arbiter
  import array_4_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ARB_ADDR_W,
  parameter int unsigned       DATA_W     = ARB_DATA_W,
  parameter int unsigned       MASK_W     = ARB_MASK_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic              clock,
  input logic              reset_n,
  array_4_arbiter_if.slave bus
);

`ifdef ARRAY_4_ARB_INIT_EN
  localparam arb_state_e RST_STATE = INIT;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_busy_c;
`else
  localparam arb_state_e RST_STATE = RUN;
`endif

  arb_state_e state_q, state_d;
  logic       init_done_q;
  logic [1:0] resp_valid_q, resp_valid_d;
  logic       run_c;
  logic       sel_c;
  logic [1:0] valid_c;
  logic [1:0] grant_c;

  // Requests are only visible to the arbiter once the array is usable.
  assign run_c   = (state_q == RUN) && init_done_q;
  assign valid_c = bus.req_valid & {2{run_c}};
  assign sel_c   = grant_c[1];

`ifdef ARRAY_4_ARB_INIT_EN
  // Clear writes only while out of reset so the macro sees no enable in reset.
  assign init_busy_c = (state_q == INIT) && reset_n;
`endif

  rr_arb2 u_arb (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .valid_i  (valid_c),
    .update_i (run_c),
    .grant_o  (grant_c)
  );

  // Client-facing outputs; read data is a straight pass of the macro output.
  assign bus.req_ready  = grant_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = bus.mem_rdata;
  assign bus.init_done  = init_done_q;

  // Next state and SRAM port drive: granted requester by default, clear in INIT.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = grant_c & ~bus.req_write;
    bus.mem_en    = |grant_c;
    bus.mem_wmode = sel_c ? bus.req_write[1] : bus.req_write[0];
    bus.mem_addr  = sel_c ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                          : bus.req_addr[ADDR_W-1:0];
    bus.mem_wmask = sel_c ? bus.req_wmask[2*MASK_W-1:MASK_W]
                          : bus.req_wmask[MASK_W-1:0];
    bus.mem_wdata = (|grant_c) ? (sel_c ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                        : bus.req_wdata[DATA_W-1:0])
                               : INIT_VALUE;
`ifdef ARRAY_4_ARB_INIT_EN
    cnt_d = cnt_q;
    if (init_busy_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_wmode = 1'b1;
      bus.mem_wmask = '1;
      bus.mem_wdata = INIT_VALUE;
      bus.mem_addr  = cnt_q;
      cnt_d         = cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_d = RUN;
      end
    end
`endif
  end

  // State, done flag and one-cycle read response tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RST_STATE;
      init_done_q  <= 1'b0;
      resp_valid_q <= 2'b00;
`ifdef ARRAY_4_ARB_INIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      init_done_q  <= (state_d == RUN);
      resp_valid_q <= resp_valid_d;
`ifdef ARRAY_4_ARB_INIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule
